set_control: RTL and testbench

Button-input front end for the clock's setting path: synchronizes and debounces three push-buttons, runs the run/edit mode state machine, and produces the `smh_dmy`, `dem_chinh` and `blink_led` controls consumed by the 7-segment display driver. In edit mode it also emits one-cycle increment strobes for the currently selected field, which go to the BCD time/date counters. It sits between the board buttons and the counter/display pair. It is the input-side counterpart of the display path.

---
 rtl/set_control.sv | 245 ++++++++++++++++++++++++
 tb/tb_set_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_control.sv
// set_control: button front end for the clock's setting path.
// Synchronizes and debounces the mode/sel/inc buttons, runs the RUN/EDIT
// mode machine and drives the display controls plus one-cycle increment
// strobes (with auto-repeat) for the BCD time/date counters.
module set_control #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int IDLE_CYCLES     = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  output logic       smh_dmy,
  output logic       dem_chinh,
  output logic [1:0] blink_led,
  output logic       inc_ss,
  output logic       inc_mm,
  output logic       inc_hh,
  output logic       inc_dd,
  output logic       inc_mo,
  output logic       inc_yy
);

  // Counter widths: one spare bit above what the terminal count needs.
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W    = $clog2(REP_MAX) + 1;
  localparam int ID_W    = $clog2(IDLE_CYCLES) + 1;

  localparam logic [DB_W-1:0] DB_LAST         = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] REP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [ID_W-1:0] IDLE_LAST       = ID_W'(IDLE_CYCLES - 1);

  // Button index: 0 = mode, 1 = sel, 2 = inc.
  logic [2:0] btn_raw;
  logic [2:0] press_evt;
  logic       inc_held;

  assign btn_raw = {btn_inc, btn_sel, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic            press_reg;
      logic [DB_W-1:0] db_cnt_reg;

      // Two-flop synchronizer feeding a saturating debouncer; a press pulse
      // is registered on the edge the stable value rises.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          press_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg >= DB_LAST) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
            press_reg  <= sync2_reg;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      assign press_evt[gi] = press_reg;

      if (gi == 2) begin : g_held
        assign inc_held = stable_reg;
      end
    end
  endgenerate

  // Same-cycle events resolve as sel > mode > inc; losers are dropped.
  logic sel_evt;
  logic mode_evt;
  logic inc_evt;

  assign sel_evt  = press_evt[1];
  assign mode_evt = press_evt[0] & ~press_evt[1];
  assign inc_evt  = press_evt[2] & ~press_evt[1] & ~press_evt[0];

  typedef enum logic {S_RUN, S_EDIT} state_t;

  state_t          state_reg;
  logic            smh_dmy_reg;
  logic            dem_chinh_reg;
  logic [1:0]      blink_reg;
  logic [5:0]      inc_reg;        // {yy, mo, dd, hh, mm, ss}
  logic            rep_active_reg;
  logic            rep_first_reg;  // still waiting out the initial delay
  logic [RP_W-1:0] rep_cnt_reg;
  logic [ID_W-1:0] idle_cnt_reg;

  // First field shown when entering a view: ss for time, yyyy for date.
  function automatic logic [1:0] first_field(input logic view);
    return view ? 2'b11 : 2'b10;
  endfunction

  // Last field of each view; a sel press there goes back to RUN.
  function automatic logic is_last_field(input logic view, input logic [1:0] field);
    return view ? (field == 2'b01) : (field == 2'b00);
  endfunction

  // One-hot strobe for the field under edit in the given view.
  function automatic logic [5:0] strobe_for(input logic view, input logic [1:0] field);
    logic [5:0] s;
    s = 6'b000000;
    if (!view) begin
      case (field)
        2'b10:   s = 6'b000001;  // ss
        2'b01:   s = 6'b000010;  // mm
        2'b00:   s = 6'b000100;  // hh
        default: s = 6'b000000;
      endcase
    end else begin
      case (field)
        2'b01:   s = 6'b001000;  // dd
        2'b10:   s = 6'b010000;  // mo
        2'b11:   s = 6'b100000;  // yy
        default: s = 6'b000000;
      endcase
    end
    return s;
  endfunction

  logic [RP_W-1:0] rep_limit;
  logic            rep_fire;
  logic            idle_expire;

  assign rep_limit   = rep_first_reg ? REP_DELAY_LAST : REP_PERIOD_LAST;
  assign rep_fire    = rep_active_reg & inc_held & (rep_cnt_reg >= rep_limit);
  assign idle_expire = (idle_cnt_reg >= IDLE_LAST);

  // Mode machine with registered outputs, auto-repeat and idle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_RUN;
      smh_dmy_reg    <= 1'b0;
      dem_chinh_reg  <= 1'b0;
      blink_reg      <= 2'b00;
      inc_reg        <= 6'b000000;
      rep_active_reg <= 1'b0;
      rep_first_reg  <= 1'b0;
      rep_cnt_reg    <= '0;
      idle_cnt_reg   <= '0;
    end else begin
      inc_reg <= 6'b000000;
      case (state_reg)
        S_RUN: begin
          rep_active_reg <= 1'b0;
          rep_cnt_reg    <= '0;
          idle_cnt_reg   <= '0;
          blink_reg      <= 2'b00;
          dem_chinh_reg  <= 1'b0;
          if (sel_evt) begin
            state_reg     <= S_EDIT;
            dem_chinh_reg <= 1'b1;
            blink_reg     <= first_field(smh_dmy_reg);
          end else if (mode_evt) begin
            smh_dmy_reg <= ~smh_dmy_reg;
          end
        end
        S_EDIT: begin
          if (sel_evt) begin
            rep_active_reg <= 1'b0;
            rep_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
            if (is_last_field(smh_dmy_reg, blink_reg)) begin
              state_reg     <= S_RUN;
              dem_chinh_reg <= 1'b0;
              blink_reg     <= 2'b00;
            end else begin
              blink_reg <= blink_reg - 2'd1;
            end
          end else if (mode_evt) begin
            smh_dmy_reg    <= ~smh_dmy_reg;
            blink_reg      <= first_field(~smh_dmy_reg);
            rep_active_reg <= 1'b0;
            rep_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
          end else if (inc_evt) begin
            inc_reg        <= strobe_for(smh_dmy_reg, blink_reg);
            rep_active_reg <= 1'b1;
            rep_first_reg  <= 1'b1;
            rep_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
          end else if (rep_fire) begin
            inc_reg       <= strobe_for(smh_dmy_reg, blink_reg);
            rep_first_reg <= 1'b0;
            rep_cnt_reg   <= '0;
            idle_cnt_reg  <= '0;
          end else if (idle_expire) begin
            state_reg      <= S_RUN;
            dem_chinh_reg  <= 1'b0;
            blink_reg      <= 2'b00;
            rep_active_reg <= 1'b0;
            rep_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
          end else begin
            if (idle_cnt_reg < IDLE_LAST) begin
              idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
            if (rep_active_reg && inc_held) begin
              if (rep_cnt_reg < rep_limit) begin
                rep_cnt_reg <= rep_cnt_reg + 1'b1;
              end
            end else begin
              // Release ends the repeat; only a fresh press re-arms it.
              rep_active_reg <= 1'b0;
              rep_cnt_reg    <= '0;
            end
          end
        end
        default: begin
          state_reg <= S_RUN;
        end
      endcase
    end
  end

  assign smh_dmy   = smh_dmy_reg;
  assign dem_chinh = dem_chinh_reg;
  assign blink_led = blink_reg;
  assign inc_ss    = inc_reg[0];
  assign inc_mm    = inc_reg[1];
  assign inc_hh    = inc_reg[2];
  assign inc_dd    = inc_reg[3];
  assign inc_mo    = inc_reg[4];
  assign inc_yy    = inc_reg[5];

endmodule

// File: tb/tb_set_control.sv
// tb_set_control: table-driven press sequences with a scoreboard queue,
// plus hand-written latency, auto-repeat, idle-timeout and reset sequences.
module tb_set_control;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int IC = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic       smh_dmy;
  logic       dem_chinh;
  logic [1:0] blink_led;
  logic       inc_ss, inc_mm, inc_hh, inc_dd, inc_mo, inc_yy;

  set_control #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .IDLE_CYCLES    (IC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_sel  (btn_sel),
    .btn_inc  (btn_inc),
    .smh_dmy  (smh_dmy),
    .dem_chinh(dem_chinh),
    .blink_led(blink_led),
    .inc_ss   (inc_ss),
    .inc_mm   (inc_mm),
    .inc_hh   (inc_hh),
    .inc_dd   (inc_dd),
    .inc_mo   (inc_mo),
    .inc_yy   (inc_yy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] strb;
  assign strb = {inc_yy, inc_mo, inc_dd, inc_hh, inc_mm, inc_ss};

  // Strobe log, sampled on the falling edge.
  int         log_cyc[$];
  logic [5:0] log_vec[$];
  always @(negedge clk) begin
    if (strb != 6'd0) begin
      log_cyc.push_back(cyc);
      log_vec.push_back(strb);
      $display("strobe cyc=%0d vec=%b", cyc, strb);
    end
  end

  typedef struct {
    string      name;
    logic [2:0] btns;   // {inc, sel, mode}
    int         hold;
    logic       smh;
    logic       dem;
    logic [1:0] blink;
    logic [5:0] strb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   rep_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] b);
    {btn_inc, btn_sel, btn_mode} = b;
  endtask

  task automatic add(input string name, input logic [2:0] b, input int hold, input logic smh,
                     input logic dem, input logic [1:0] blink, input logic [5:0] s);
    vec_t v;
    v.name = name; v.btns = b; v.hold = hold; v.smh = smh; v.dem = dem;
    v.blink = blink; v.strb = s;
    vecs.push_back(v);
  endtask

  task automatic scan(input int lo, input int hi, output int cnt, output logic [5:0] orv);
    cnt = 0;
    orv = 6'd0;
    foreach (log_cyc[i]) begin
      if (log_cyc[i] > lo && log_cyc[i] <= hi) begin
        cnt++;
        orv |= log_vec[i];
      end
    end
  endtask

  initial begin
    int         s;
    int         r;
    int         cnt;
    logic [5:0] orv;
    vec_t       v;
    vec_t       ev;
    int         offs[5];

    // Press sequences starting from EDIT, time view, field ss.
    add("glitch",      3'b010, 3, 1'b0, 1'b1, 2'b10, 6'b000000);
    add("sel_mm",      3'b010, 8, 1'b0, 1'b1, 2'b01, 6'b000000);
    add("sel_hh",      3'b010, 8, 1'b0, 1'b1, 2'b00, 6'b000000);
    add("sel_run",     3'b010, 8, 1'b0, 1'b0, 2'b00, 6'b000000);
    add("cyc_ss",      3'b010, 8, 1'b0, 1'b1, 2'b10, 6'b000000);
    add("cyc_mm",      3'b010, 8, 1'b0, 1'b1, 2'b01, 6'b000000);
    add("cyc_hh",      3'b010, 8, 1'b0, 1'b1, 2'b00, 6'b000000);
    add("cyc_run",     3'b010, 8, 1'b0, 1'b0, 2'b00, 6'b000000);
    add("inc_in_run",  3'b100, 8, 1'b0, 1'b0, 2'b00, 6'b000000);
    add("mode_run",    3'b001, 8, 1'b1, 1'b0, 2'b00, 6'b000000);
    add("date_yy",     3'b010, 8, 1'b1, 1'b1, 2'b11, 6'b000000);
    add("inc_yy",      3'b100, 8, 1'b1, 1'b1, 2'b11, 6'b100000);
    add("date_mo",     3'b010, 8, 1'b1, 1'b1, 2'b10, 6'b000000);
    add("inc_mo",      3'b100, 8, 1'b1, 1'b1, 2'b10, 6'b010000);
    add("date_dd",     3'b010, 8, 1'b1, 1'b1, 2'b01, 6'b000000);
    add("inc_dd",      3'b100, 8, 1'b1, 1'b1, 2'b01, 6'b001000);
    add("mode_edit_t", 3'b001, 8, 1'b0, 1'b1, 2'b10, 6'b000000);
    add("inc_ss",      3'b100, 8, 1'b0, 1'b1, 2'b10, 6'b000001);
    add("sel_to_mm",   3'b010, 8, 1'b0, 1'b1, 2'b01, 6'b000000);
    add("sel_inc_sim", 3'b110, 8, 1'b0, 1'b1, 2'b00, 6'b000000);
    add("inc_hh",      3'b100, 8, 1'b0, 1'b1, 2'b00, 6'b000100);
    add("sel_mode_sim",3'b011, 8, 1'b0, 1'b0, 2'b00, 6'b000000);
    add("re_ss",       3'b010, 8, 1'b0, 1'b1, 2'b10, 6'b000000);
    add("re_mm",       3'b010, 8, 1'b0, 1'b1, 2'b01, 6'b000000);
    add("inc_mm",      3'b100, 8, 1'b0, 1'b1, 2'b01, 6'b000010);
    add("mode_on_mm",  3'b001, 8, 1'b1, 1'b1, 2'b11, 6'b000000);
    add("mode_back",   3'b001, 8, 1'b0, 1'b1, 2'b10, 6'b000000);
    add("sel_mm_rep",  3'b010, 8, 1'b0, 1'b1, 2'b01, 6'b000000);

    // Reset state.
    rst = 1'b1;
    tick(3);
    check("rst_smh", smh_dmy, 0);
    check("rst_dem", dem_chinh, 0);
    check("rst_blink", blink_led, 0);
    check("rst_strb", strb, 0);
    rst = 1'b0;
    tick(2);

    // Press latency: output changes on the 7th edge after the first high sample.
    drive(3'b010);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("lat_pre_dem", dem_chinh, 0);
      check("lat_pre_blink", blink_led, 0);
    end
    check("lat_pre_smh", smh_dmy, 0);
    check("lat_pre_strb", strb, 0);
    tick(1);
    check("lat_dem", dem_chinh, 1);
    check("lat_blink", blink_led, 2'b10);
    tick(3);
    drive(3'b000);
    tick(10);

    // Table-driven press sequences.
    foreach (vecs[i]) begin
      v = vecs[i];
      s = cyc;
      drive(v.btns);
      exp_q.push_back(v);
      tick(v.hold);
      drive(3'b000);
      tick(20 - v.hold);
      ev = exp_q.pop_front();
      $display("vec %0d %s: smh=%0d dem=%0d blink=%b", i, ev.name, smh_dmy, dem_chinh, blink_led);
      check({ev.name, "_smh"}, smh_dmy, ev.smh);
      check({ev.name, "_dem"}, dem_chinh, ev.dem);
      check({ev.name, "_blink"}, blink_led, ev.blink);
      scan(s, cyc, cnt, orv);
      check({ev.name, "_strb"}, orv, ev.strb);
      check({ev.name, "_nstrb"}, cnt, (ev.strb != 6'd0) ? 1 : 0);
    end

    // Auto-repeat on mm: strobes at T, T+20, T+28, T+36, T+44, none after release.
    offs = '{7, 27, 35, 43, 51};
    s = cyc;
    drive(3'b100);
    foreach (offs[i]) rep_q.push_back(s + offs[i]);
    tick(50);
    drive(3'b000);
    tick(20);
    foreach (log_cyc[i]) begin
      if (log_cyc[i] > s) begin
        if (rep_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rep_extra: got strobe at cyc %0d expected none", log_cyc[i]);
        end else begin
          r = rep_q.pop_front();
          check("rep_time", log_cyc[i], r);
          check("rep_field", log_vec[i], 6'b000010);
        end
      end
    end
    check("rep_missing", rep_q.size(), 0);

    // Idle timeout: mode press at edge X, RUN at X+100, view preserved.
    drive(3'b001);
    tick(7);
    check("idle_entry_smh", smh_dmy, 1);
    check("idle_entry_blink", blink_led, 2'b11);
    tick(1);
    drive(3'b000);
    tick(98);
    check("idle_pre_dem", dem_chinh, 1);
    tick(1);
    check("idle_dem", dem_chinh, 0);
    check("idle_blink", blink_led, 0);
    check("idle_smh", smh_dmy, 1);
    tick(5);

    // Reset while btn_inc is held during auto-repeat.
    drive(3'b010);
    tick(8);
    drive(3'b000);
    tick(12);
    check("rr_dem", dem_chinh, 1);
    check("rr_blink", blink_led, 2'b11);
    s = cyc;
    drive(3'b100);
    tick(30);
    rst = 1'b1;
    tick(1);
    r = cyc;
    check("rr_rst_smh", smh_dmy, 0);
    check("rr_rst_dem", dem_chinh, 0);
    check("rr_rst_blink", blink_led, 0);
    check("rr_rst_strb", strb, 0);
    tick(1);
    rst = 1'b0;
    tick(40);
    drive(3'b000);
    tick(12);
    scan(s, r - 1, cnt, orv);
    check("rr_pre_cnt", cnt, 2);
    check("rr_pre_field", orv, 6'b100000);
    scan(r - 1, cyc, cnt, orv);
    check("rr_post_cnt", cnt, 0);
    check("rr_post_dem", dem_chinh, 0);

    // Exclusivity and width over every strobe seen.
    foreach (log_cyc[i]) begin
      check("onehot", $onehot(log_vec[i]), 1);
      if (i > 0) check("width", (log_cyc[i] - log_cyc[i-1]) > 1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
